// File: rtl/ex_pkg.sv
// Shared types and encodings for the execute stage: opcodes, branch ops,
// B-operand source selects, flag bit positions and the stage FSM states.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_ANDN = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_ROL  = 4'd9,
        OP_ROR  = 4'd10,
        OP_SEQ  = 4'd11,
        OP_SLT  = 4'd12,
        OP_SLE  = 4'd13,
        OP_SCO  = 4'd14,
        OP_MUL  = 4'd15
    } op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQZ = 3'd1,
        BR_BNEZ = 3'd2,
        BR_BLTZ = 3'd3,
        BR_BGEZ = 3'd4,
        BR_JIMM = 3'd5,
        BR_JREG = 3'd6
    } brop_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_t;

    localparam logic [1:0] BSEL_RD2  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_SLBI = 2'd2;
    localparam logic [1:0] BSEL_ZERO = 2'd3;

    // Flag vector layout is {S, Z, O, C}.
    localparam int FLAG_C = 0;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 3;

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-side and memory-side handshake bundle of the execute stage, plus
// the fetch redirect and busy indication.
interface execute_pipe_if #(
    parameter int WIDTH = 16
);
    import ex_pkg::*;

    // valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, payload holds while valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    op_t              in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_rd2;
    logic [WIDTH-1:0] in_imm;
    logic [1:0]       in_bsel;
    brop_t            in_brop;
    logic [WIDTH-1:0] in_bimm;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             busy;

    modport master (
        output in_valid, in_pc, in_op, in_a, in_rd2, in_imm, in_bsel,
               in_brop, in_bimm, in_flush, out_ready,
        input  in_ready, out_valid, out_result, out_flags,
               redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  in_valid, in_pc, in_op, in_a, in_rd2, in_imm, in_bsel,
               in_brop, in_bimm, in_flush, out_ready,
        output in_ready, out_valid, out_result, out_flags,
               redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle. done pulses in the
// WIDTH-th iteration with the final low product available combinationally.
module ex_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = running && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage: ALU, flags, branch resolution, iterative MUL,
// EX/MEM output register with back-pressure and a one-cycle fetch redirect.
// WIDTH must be a power of two and at least 9 (SLBI keeps a[WIDTH-9:0]).
module execute_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    execute_pipe_if.slave ex,
    output ex_state_t     dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    ex_state_t state_q, state_d;

    logic             in_ready_w, accept, is_mul, mul_start, mul_done;
    logic [WIDTH-1:0] a, b, b_add, alu_res, mul_prod, target;
    logic [WIDTH:0]   add_full;
    logic             sub_mode, add_c, add_o, arith, taken;
    logic [SHW-1:0]   amt;
    logic [2*WIDTH-1:0] rol_w, ror_w;
    logic [3:0]       alu_flags, mul_flags;

    logic             out_valid_q, redirect_valid_q;
    logic [WIDTH-1:0] out_result_q, redirect_pc_q;
    logic [3:0]       out_flags_q;

    assign in_ready_w = rst_n & (state_q != ST_MUL) & ~ex.in_flush
                        & (~out_valid_q | ex.out_ready);
    assign accept     = ex.in_valid & in_ready_w;
    assign is_mul     = MUL_EN && (ex.in_op == OP_MUL);
    assign mul_start  = accept & is_mul;

    // Operand and adder network; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        a = ex.in_a;
        case (ex.in_bsel)
            BSEL_RD2:  b = ex.in_rd2;
            BSEL_IMM:  b = ex.in_imm;
            BSEL_SLBI: b = {ex.in_a[WIDTH-9:0], ex.in_imm[7:0]};
            default:   b = '0;
        endcase
        sub_mode = (ex.in_op == OP_SUB);
        b_add    = sub_mode ? ~b : b;
        add_full = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub_mode};
        add_c    = add_full[WIDTH];
        add_o    = (a[WIDTH-1] == b_add[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
        amt      = b[SHW-1:0];
        rol_w    = {a, a} << amt;
        ror_w    = {a, a} >> amt;
    end

    always_comb begin
        alu_res = '0;
        arith   = 1'b0;
        case (ex.in_op)
            OP_ADD, OP_SUB, OP_MUL: begin
                alu_res = add_full[WIDTH-1:0];
                arith   = 1'b1;
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ANDN: alu_res = a & ~b;
            OP_SLL:  alu_res = a << amt;
            OP_SRL:  alu_res = a >> amt;
            OP_SRA:  alu_res = $signed(a) >>> amt;
            OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
            OP_ROR:  alu_res = ror_w[WIDTH-1:0];
            OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
            OP_SCO: begin
                alu_res = {{(WIDTH-1){1'b0}}, add_c};
                arith   = 1'b1;
            end
            default: alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_S] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_O] = arith & add_o;
        alu_flags[FLAG_C] = arith & add_c;
        mul_flags         = '0;
        mul_flags[FLAG_S] = mul_prod[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_prod == '0);
    end

    always_comb begin
        case (ex.in_brop)
            BR_BEQZ: taken = (a == '0);
            BR_BNEZ: taken = (a != '0);
            BR_BLTZ: taken = a[WIDTH-1];
            BR_BGEZ: taken = ~a[WIDTH-1];
            BR_JIMM: taken = 1'b1;
            BR_JREG: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        target = (ex.in_brop == BR_JREG) ? alu_res : ex.in_pc + ex.in_bimm;
    end

    ex_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (ex.in_flush),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (ex.in_flush || mul_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A finishing MUL never meets a stalled output: MUL is only accepted
    // when the output register is empty or draining, and nothing else loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_flags_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (ex.in_flush) begin
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            redirect_valid_q <= accept & taken;
            if (accept && taken) begin
                redirect_pc_q <= target;
            end
            if (mul_done) begin
                out_valid_q  <= 1'b1;
                out_result_q <= mul_prod;
                out_flags_q  <= mul_flags;
            end else if (accept && !is_mul) begin
                out_valid_q  <= 1'b1;
                out_result_q <= alu_res;
                out_flags_q  <= alu_flags;
            end else if (ex.out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign ex.in_ready       = in_ready_w;
    assign ex.out_valid      = out_valid_q;
    assign ex.out_result     = out_result_q;
    assign ex.out_flags      = out_flags_q;
    assign ex.redirect_valid = redirect_valid_q;
    assign ex.redirect_pc    = redirect_pc_q;
    assign ex.busy           = (state_q == ST_MUL);
    assign dbg_state         = state_q;

endmodule
